// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the WISC CPU front end.
//   - ADDR_W / XLEN   : address and instruction word widths (16 bits each)
//   - INSTR_BYTES     : byte distance between consecutive instructions
//   - OP_HLT          : opcode (instr[15:12]) that halts fetch
//   - fetch_state_e   : fetch FSM state encoding
//   - opcode_of()     : extracts the opcode field from an instruction word
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int XLEN   = 16;

    localparam logic [ADDR_W-1:0] INSTR_BYTES = 16'd2;
    localparam logic [3:0]        OP_HLT      = 4'hF;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,  // ready to issue a read for pc
        FS_WAIT  = 2'd1,  // read accepted, waiting for its data
        FS_DRAIN = 2'd2,  // redirected with a read in flight; its data is dropped
        FS_HALT  = 2'd3   // HLT fetched; no more reads until redirected
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [XLEN-1:0] word);
        return word[XLEN-1:XLEN-4];
    endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with sequential increment and redirect load.
//   clk, rst    : clock, synchronous active-high reset (loads RESET_PC)
//   load_en     : load load_pc (bit 0 forced to zero); wins over inc_en
//   load_pc     : redirect target
//   inc_en      : advance to the next sequential instruction
//   pc          : current program counter
//   pc_plus2    : pc + 2, wrapping modulo 2^16
// -----------------------------------------------------------------------------
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus2
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Instructions are halfword aligned, so the redirect LSB is dropped.
    logic unused_load_lsb;
    assign unused_load_lsb = load_pc[0];

    // Plain 16-bit add: the carry out is discarded, giving 16'hFFFE -> 16'h0000.
    assign pc_plus2 = pc_q + INSTR_BYTES;
    assign pc       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = {load_pc[ADDR_W-1:1], 1'b0};
        end else if (inc_en) begin
            pc_d = pc_plus2;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch for the WISC CPU. Owns the PC, keeps at most one
// instruction-memory read outstanding and hands each fetched word, with its
// address and address+2, to decode through a valid/stall output slot.
//   clk, rst           : clock, synchronous active-high reset
//   imem_req/imem_addr : read request and address (combinational)
//   imem_ready         : memory accepts the request this cycle
//   imem_rvalid/rdata  : read response, at least one cycle after acceptance
//   stall              : decode cannot take the slot this cycle
//   redirect/_pc       : branch/jump; restart fetch at redirect_pc
//   instr_valid, instr, instr_pc, pc_plus2 : output slot to decode
//   pc                 : current fetch PC
//   hlt                : fetch halted after a HLT instruction
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]        HLT_OPCODE = OP_HLT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus2,
    output logic [ADDR_W-1:0] pc,
    output logic              hlt
);

    fetch_state_e      state_q, state_d;
    logic              instr_valid_q, instr_valid_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] pc_plus2_q, pc_plus2_d;
    logic              hlt_q, hlt_d;

    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_cur;
    logic [ADDR_W-1:0] pc_seq;

    logic              slot_open;
    logic              req_fire;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load_en  (pc_load),
        .load_pc  (redirect_pc),
        .inc_en   (pc_inc),
        .pc       (pc_cur),
        .pc_plus2 (pc_seq)
    );

    // A new read is only issued when its result is guaranteed a place to land:
    // the slot is empty now or decode takes it at this edge.
    assign slot_open = !instr_valid_q || !stall;
    assign imem_req  = (state_q == FS_REQ) && slot_open;
    assign imem_addr = pc_cur;
    assign req_fire  = imem_req && imem_ready;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q && stall;  // drops when decode consumes it
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pc_plus2_d    = pc_plus2_q;
        hlt_d         = hlt_q;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;

        if (redirect) begin
            // Redirect flushes the slot even under stall and abandons any
            // read whose data has not yet come back.
            pc_load       = 1'b1;
            instr_valid_d = 1'b0;
            hlt_d         = 1'b0;
            case (state_q)
                FS_REQ:   state_d = req_fire ? FS_DRAIN : FS_REQ;
                // A response arriving together with the redirect is the one
                // in flight: it is dropped here and nothing is left to drain.
                FS_WAIT:  state_d = imem_rvalid ? FS_REQ : FS_DRAIN;
                FS_DRAIN: state_d = imem_rvalid ? FS_REQ : FS_DRAIN;
                FS_HALT:  state_d = FS_REQ;
            endcase
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (req_fire) begin
                        state_d = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    // The read was issued only with the slot free or being
                    // consumed, so the slot is always empty here.
                    if (imem_rvalid) begin
                        instr_valid_d = 1'b1;
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_cur;
                        pc_plus2_d    = pc_seq;
                        if (opcode_of(imem_rdata) == HLT_OPCODE) begin
                            // pc stays on the HLT so a later redirect is the
                            // only way forward.
                            state_d = FS_HALT;
                            hlt_d   = 1'b1;
                        end else begin
                            state_d = FS_REQ;
                            pc_inc  = 1'b1;
                        end
                    end
                end
                FS_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = FS_REQ;
                    end
                end
                FS_HALT: begin
                    state_d = FS_HALT;
                end
            endcase
        end
    end

    // NOTE: the output slot data registers are reset too, so decode never
    // sees X on instr/instr_pc/pc_plus2 even while instr_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_REQ;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            pc_plus2_q    <= '0;
            hlt_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            pc_plus2_q    <= pc_plus2_d;
            hlt_q         <= hlt_d;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus2    = pc_plus2_q;
    assign pc          = pc_cur;
    assign hlt         = hlt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural instruction memory with
// programmable latency/ready answers reads; expected (pc, instr) pairs are
// queued by each scenario and popped whenever decode consumes the slot.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic [15:0] pc;
    logic        hlt;

    fetch_stage #(
        .RESET_PC   (16'h0000),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus2    (pc_plus2),
        .pc          (pc),
        .hlt         (hlt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mon_p2;
    bit          mon_en = 1'b0;

    logic [15:0] mem [0:65535];
    int          lat_min    = 1;
    int          lat_max    = 1;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: never
    bit          pending    = 1'b0;
    int          deliver_at = 0;
    logic [15:0] pend_addr  = 16'h0000;
    int          mcyc       = 0;

    // Memory model and slot monitor; both act 2 time units after each
    // falling edge, after scenario tasks have driven their inputs.
    initial begin : mem_and_monitor
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            #2;
            mcyc++;
            if (rst) begin
                pending     = 1'b0;
                imem_rvalid = 1'b0;
                imem_ready  = 1'b0;
            end else begin
                if (imem_req) begin
                    checks++;
                    if (pending) begin
                        errors++;
                        $display("FAIL outstanding: imem_req=1 at addr %h while read of %h still in flight, required 0",
                                 imem_addr, pend_addr);
                    end
                end
                if (pending && mcyc >= deliver_at) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[pend_addr];
                    pending     = 1'b0;
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = 16'($urandom);
                end
                case (ready_mode)
                    0:       imem_ready = 1'b1;
                    1:       imem_ready = 1'($urandom_range(1, 0));
                    default: imem_ready = 1'b0;
                endcase
                if (imem_req && imem_ready) begin
                    pending    = 1'b1;
                    pend_addr  = imem_addr;
                    deliver_at = mcyc + int'($urandom_range(lat_max, lat_min));
                end
            end

            if (!rst && mon_en && instr_valid && !stall && !redirect) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: got instr=%h pc=%h, required no delivery", instr, instr_pc);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_p2 = mon_e.pc + 16'd2;
                    if ({instr, instr_pc, pc_plus2} !== {mon_e.instr, mon_e.pc, mon_p2}) begin
                        errors++;
                        $display("FAIL stream: got instr=%h pc=%h pc_plus2=%h, required instr=%h pc=%h pc_plus2=%h",
                                 instr, instr_pc, pc_plus2, mon_e.instr, mon_e.pc, mon_p2);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mon_en      = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at 3 units after a falling edge; returns at the same phase.
    task automatic wait_valid(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (instr_valid === 1'b1) begin
                checks++;
                return;
            end
            @(negedge clk);
            #3;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: instr_valid still %b after %0d cycles, required 1", name, instr_valid, budget);
    endtask

    task automatic wait_empty(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                return;
            end
            @(negedge clk);
            #3;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: %0d expected instructions never delivered, required 0", name, exp_q.size());
    endtask

    task automatic test_reset();
        ready_mode = 2;
        rst        = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc: got %h, required 0000", pc);
        end
        checks++;
        if ({instr_valid, hlt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b hlt=%b, required 0 0", instr_valid, hlt);
        end
        checks++;
        if ({instr, instr_pc, pc_plus2} !== 48'h0) begin
            errors++;
            $display("FAIL reset_slot: got instr=%h pc=%h pc_plus2=%h, required all 0000", instr, instr_pc, pc_plus2);
        end
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        ready_mode = 0; lat_min = 1; lat_max = 1;
        mem[16'h0000] = 16'h1234;
        mem[16'h0002] = 16'h5678;
        do_reset();
        exp_q.push_back('{pc: 16'h0000, instr: 16'h1234});
        exp_q.push_back('{pc: 16'h0002, instr: 16'h5678});
        mon_en = 1'b1;
        #3;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL basic_req0: got req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
        @(negedge clk); #3;
        checks++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            errors++;
            $display("FAIL basic_wait: got req=%b valid=%b, required 0 0", imem_req, instr_valid);
        end
        @(negedge clk); #3;
        checks++;
        if ({instr_valid, instr, instr_pc, pc_plus2} !== {1'b1, 16'h1234, 16'h0000, 16'h0002}) begin
            errors++;
            $display("FAIL basic_first: got v=%b instr=%h pc=%h p2=%h, required 1 1234 0000 0002",
                     instr_valid, instr, instr_pc, pc_plus2);
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL basic_req2: got req=%b addr=%h, required 1 0002", imem_req, imem_addr);
        end
        @(negedge clk); #3;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_gap: got valid=%b, required 0", instr_valid);
        end
        @(negedge clk); #3;
        checks++;
        if ({instr_valid, instr, instr_pc, pc_plus2} !== {1'b1, 16'h5678, 16'h0002, 16'h0004}) begin
            errors++;
            $display("FAIL basic_second: got v=%b instr=%h pc=%h p2=%h, required 1 5678 0002 0004",
                     instr_valid, instr, instr_pc, pc_plus2);
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin
            errors++;
            $display("FAIL basic_req4: got req=%b addr=%h, required 1 0004", imem_req, imem_addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drained: got %0d pending, required 0", exp_q.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic test_stall();
        ready_mode = 0; lat_min = 1; lat_max = 1;
        mem[16'h0000] = 16'h1234;
        mem[16'h0002] = 16'h5678;
        do_reset();
        exp_q.push_back('{pc: 16'h0000, instr: 16'h1234});
        exp_q.push_back('{pc: 16'h0002, instr: 16'h5678});
        mon_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            checks++;
            if ({instr_valid, instr, instr_pc, pc_plus2, imem_req} !== {1'b1, 16'h1234, 16'h0000, 16'h0002, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b instr=%h pc=%h p2=%h req=%b, required 1 1234 0000 0002 0",
                         i, instr_valid, instr, instr_pc, pc_plus2, imem_req);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        #3;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL stall_resume: got req=%b addr=%h, required 1 0002", imem_req, imem_addr);
        end
        wait_empty(10, "stall");
        mon_en = 1'b0;
    endtask

    task automatic test_redirect();
        ready_mode = 0; lat_min = 3; lat_max = 3;
        mem[16'h0000] = 16'hDEAD;
        mem[16'h0040] = 16'h1111;
        do_reset();
        exp_q.push_back('{pc: 16'h0040, instr: 16'h1111});
        mon_en = 1'b1;
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        #3;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_req: got %b, required 0", imem_req);
        end
        @(negedge clk);
        redirect = 1'b0;
        #3;
        checks++;
        if ({pc, imem_req, instr_valid} !== {16'h0040, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL redir_drain: got pc=%h req=%b valid=%b, required 0040 0 0", pc, imem_req, instr_valid);
        end
        @(negedge clk); #3;
        @(negedge clk); #3;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            errors++;
            $display("FAIL redir_refetch: got req=%b addr=%h valid=%b, required 1 0040 0", imem_req, imem_addr, instr_valid);
        end
        wait_empty(20, "redirect");
        mon_en = 1'b0;
    endtask

    task automatic test_redirect_corners();
        ready_mode = 0; lat_min = 2; lat_max = 2;
        mem[16'h0000] = 16'hDEAD;
        mem[16'h0080] = 16'h2080;
        mem[16'h00A0] = 16'h20A0;
        do_reset();
        mon_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // response for 0000 arrives in this cycle together with the redirect
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        @(negedge clk);
        redirect = 1'b0;
        #3;
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0080, 1'b0}) begin
            errors++;
            $display("FAIL redir_rvalid: got req=%b addr=%h valid=%b, required 1 0080 0", imem_req, imem_addr, instr_valid);
        end
        @(negedge clk);
        stall = 1'b1;
        #3;
        wait_valid(10, "corner_fill");
        checks++;
        if (instr !== 16'h2080) begin
            errors++;
            $display("FAIL corner_instr: got %h, required 2080", instr);
        end
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'h00A0;
        exp_q.push_back('{pc: 16'h00A0, instr: 16'h20A0});
        @(negedge clk);
        redirect = 1'b0;
        #3;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h00A0}) begin
            errors++;
            $display("FAIL redir_stall_flush: got valid=%b req=%b addr=%h, required 0 1 00A0", instr_valid, imem_req, imem_addr);
        end
        @(negedge clk);
        stall = 1'b0;
        #3;
        wait_empty(20, "corner");
        mon_en = 1'b0;
    endtask

    task automatic test_halt();
        ready_mode = 2; lat_min = 1; lat_max = 1;
        mem[16'h0010] = 16'hF000;
        mem[16'h0020] = 16'h2222;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        @(negedge clk);
        redirect   = 1'b0;
        ready_mode = 0;
        exp_q.push_back('{pc: 16'h0010, instr: 16'hF000});
        mon_en = 1'b1;
        #3;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0010}) begin
            errors++;
            $display("FAIL halt_req: got req=%b addr=%h, required 1 0010", imem_req, imem_addr);
        end
        wait_valid(10, "halt_fill");
        checks++;
        if ({instr, hlt, imem_req} !== {16'hF000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL halt_deliver: got instr=%h hlt=%b req=%b, required F000 1 0", instr, hlt, imem_req);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            checks++;
            if ({imem_req, hlt, instr_valid, pc} !== {1'b0, 1'b1, 1'b0, 16'h0010}) begin
                errors++;
                $display("FAIL halt_idle[%0d]: got req=%b hlt=%b valid=%b pc=%h, required 0 1 0 0010",
                         i, imem_req, hlt, instr_valid, pc);
            end
        end
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        exp_q.push_back('{pc: 16'h0020, instr: 16'h2222});
        @(negedge clk);
        redirect = 1'b0;
        #3;
        checks++;
        if ({hlt, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0020}) begin
            errors++;
            $display("FAIL halt_exit: got hlt=%b req=%b addr=%h, required 0 1 0020", hlt, imem_req, imem_addr);
        end
        wait_empty(10, "halt");
        mon_en = 1'b0;
    endtask

    task automatic test_wrap();
        ready_mode = 2; lat_min = 1; lat_max = 1;
        mem[16'hFFFE] = 16'h3333;
        mem[16'h0000] = 16'h4444;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect   = 1'b0;
        ready_mode = 0;
        exp_q.push_back('{pc: 16'hFFFE, instr: 16'h3333});
        exp_q.push_back('{pc: 16'h0000, instr: 16'h4444});
        mon_en = 1'b1;
        #3;
        wait_valid(10, "wrap_fill");
        checks++;
        if ({instr, instr_pc, pc_plus2, imem_addr} !== {16'h3333, 16'hFFFE, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL wrap: got instr=%h pc=%h p2=%h addr=%h, required 3333 FFFE 0000 0000",
                     instr, instr_pc, pc_plus2, imem_addr);
        end
        wait_empty(10, "wrap");
        mon_en = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] w;
        ready_mode = 1; lat_min = 1; lat_max = 6;
        for (int a = 0; a < 256; a += 2) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(14, 0));
            mem[a] = w;
        end
        do_reset();
        for (int i = 0; i < 80; i++) begin
            exp_q.push_back('{pc: 16'(2 * i), instr: mem[2 * i]});
        end
        mon_en = 1'b1;
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            stall = ($urandom_range(9, 0) < 3);
            #3;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_timeout: %0d instructions undelivered, required 0", exp_q.size());
        end
        stall  = 1'b0;
        mon_en = 1'b0;
    endtask

    initial begin : main
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'h1000 | 16'(a & 16'h0FFF);
        end
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_corners();
        test_halt();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
